// File: rtl/m_code_acq_ctrl.sv
// m_code_acq_ctrl
// ---------------
// Code-phase acquisition controller for the 11-stage M-code generator.
// The controller slides the generator's local code one chip at a time by
// pulsing shift_parse. At each phase it correlates loc_chip against rx_chip
// over DWELL_CHIPS chips, sampling once per chip at chip_cnt == SAMPLE_PT.
// It declares lock when the agreement count reaches THRESH.
//
// Optional feature macro: ACQ_TRACK_EN
//   defined   : LOCK keeps dwelling. LOSS_CNT consecutive missed dwells drop
//               lock, and the search resumes from the next phase.
//   undefined : LOCK is terminal, and the counters and corr_val are frozen.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse; honoured in IDLE, LOCK and FAIL
//   abort        : level; forces IDLE and has priority over start
//   rx_chip      : received hard-decision chip
//   loc_chip     : generator m_code output
//   shift_parse  : registered one-cycle pulse to the generator (SHIFT cycle)
//   busy         : high in DWELL / CHECK / SHIFT / LOCK
//   locked       : lock flag
//   fail         : sticky; set when every phase has been searched without a hit
//   phase_idx    : shifts applied since start, modulo CODE_LEN
//   corr_val     : agreement count of the last completed dwell
//
// Handshake: there is no valid/ready traffic. start is a single-cycle
// request sampled on the clock edge. abort is a level sampled every edge.
// shift_parse is a single-cycle strobe that the generator samples on the
// edge that ends the SHIFT cycle.
module m_code_acq_ctrl #(
  parameter int CHIP_DIV    = 3052,
  parameter int SAMPLE_PT   = 1526,
  parameter int DWELL_CHIPS = 64,
  parameter int THRESH      = 48,
  parameter int CODE_LEN    = 2047,
  parameter int LOSS_CNT    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        rx_chip,
  input  logic        loc_chip,
  output logic        shift_parse,
  output logic        busy,
  output logic        locked,
  output logic        fail,
  output logic [10:0] phase_idx,
  output logic [7:0]  corr_val
);

`ifdef ACQ_TRACK_EN
  localparam bit TRACK_EN = 1'b1;
`else
  localparam bit TRACK_EN = 1'b0;
`endif

  localparam logic [11:0] CHIP_LAST  = 12'(CHIP_DIV - 1);
  localparam logic [11:0] SAMPLE_AT  = 12'(SAMPLE_PT);
  localparam logic [7:0]  DWELL_N    = 8'(DWELL_CHIPS);
  localparam logic [7:0]  THRESH_N   = 8'(THRESH);
  localparam logic [10:0] LAST_PHASE = 11'(CODE_LEN - 1);
  localparam logic [7:0]  LOSS_N     = 8'(LOSS_CNT);

  typedef enum logic [2:0] {
    S_IDLE, S_DWELL, S_CHECK, S_SHIFT, S_LOCK, S_FAIL
  } state_t;

  state_t      state, state_nx;
  logic [11:0] chip_cnt, chip_nx;
  logic [7:0]  agree_cnt, agree_nx;
  logic [7:0]  done_cnt, done_nx;
  logic [10:0] search_cnt, search_nx;
  logic [7:0]  miss_cnt, miss_nx;
  logic        resume, resume_nx;
  logic [10:0] phase_nx;
  logic [7:0]  corr_nx;
  logic        locked_nx, fail_nx, shift_nx;

  logic        sample;
  logic [7:0]  agree_inc, done_inc;
  logic [11:0] chip_step;

  assign sample    = (chip_cnt == SAMPLE_AT);
  assign agree_inc = agree_cnt + {7'd0, (rx_chip == loc_chip)};
  assign done_inc  = done_cnt + 8'd1;
  assign chip_step = (chip_cnt == CHIP_LAST) ? 12'd0 : chip_cnt + 12'd1;

  assign busy = (state == S_DWELL) || (state == S_CHECK) ||
                (state == S_SHIFT) || (state == S_LOCK);

  always_comb begin
    state_nx  = state;
    chip_nx   = chip_cnt;
    agree_nx  = agree_cnt;
    done_nx   = done_cnt;
    search_nx = search_cnt;
    miss_nx   = miss_cnt;
    resume_nx = resume;
    phase_nx  = phase_idx;
    corr_nx   = corr_val;
    locked_nx = locked;
    fail_nx   = fail;
    shift_nx  = 1'b0;

    if (abort) begin
      state_nx  = S_IDLE;
      chip_nx   = 12'd0;
      agree_nx  = 8'd0;
      done_nx   = 8'd0;
      search_nx = 11'd0;
      miss_nx   = 8'd0;
      resume_nx = 1'b0;
      locked_nx = 1'b0;
      fail_nx   = 1'b0;
    end else if (start && ((state == S_IDLE) || (state == S_LOCK) || (state == S_FAIL))) begin
      state_nx  = S_DWELL;
      chip_nx   = 12'd0;
      agree_nx  = 8'd0;
      done_nx   = 8'd0;
      search_nx = 11'd0;
      miss_nx   = 8'd0;
      resume_nx = 1'b0;
      phase_nx  = 11'd0;
      locked_nx = 1'b0;
      fail_nx   = 1'b0;
    end else begin
      case (state)
        S_DWELL: begin
          chip_nx = chip_step;
          if (sample) begin
            agree_nx = agree_inc;
            done_nx  = done_inc;
            if (done_inc == DWELL_N) state_nx = S_CHECK;
          end
        end
        S_CHECK: begin
          // chip_cnt keeps running so a tracking dwell in LOCK stays on the
          // generator's chip grid; the next sample is a whole chip away.
          chip_nx  = chip_step;
          corr_nx  = agree_cnt;
          agree_nx = 8'd0;
          done_nx  = 8'd0;
          if (agree_cnt >= THRESH_N) begin
            state_nx  = S_LOCK;
            locked_nx = 1'b1;
            miss_nx   = 8'd0;
          end else if (search_cnt == LAST_PHASE) begin
            state_nx = S_FAIL;
            fail_nx  = 1'b1;
          end else begin
            state_nx = S_SHIFT;
            shift_nx = 1'b1;
          end
        end
        S_SHIFT: begin
          // Cleared on the same edge the generator sees shift_parse, which
          // keeps both chip counters phase-aligned.
          chip_nx   = 12'd0;
          agree_nx  = 8'd0;
          done_nx   = 8'd0;
          phase_nx  = (phase_idx == LAST_PHASE) ? 11'd0 : phase_idx + 11'd1;
          // The shift that follows a loss of lock only steps off the lost
          // phase. The new search then gives every one of the CODE_LEN
          // phases a dwell, starting from a count of zero.
          search_nx = resume ? 11'd0 : search_cnt + 11'd1;
          resume_nx = 1'b0;
          state_nx  = S_DWELL;
        end
        S_LOCK: begin
          if (TRACK_EN) begin
            chip_nx = chip_step;
            if (sample) begin
              agree_nx = agree_inc;
              done_nx  = done_inc;
              if (done_inc == DWELL_N) begin
                corr_nx  = agree_inc;
                agree_nx = 8'd0;
                done_nx  = 8'd0;
                if (agree_inc >= THRESH_N) begin
                  miss_nx = 8'd0;
                end else if (miss_cnt + 8'd1 == LOSS_N) begin
                  locked_nx = 1'b0;
                  search_nx = 11'd0;
                  miss_nx   = 8'd0;
                  resume_nx = 1'b1;
                  state_nx  = S_SHIFT;
                  shift_nx  = 1'b1;
                end else begin
                  miss_nx = miss_cnt + 8'd1;
                end
              end
            end
          end
        end
        default: ; // IDLE and FAIL wait for start
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      chip_cnt    <= 12'd0;
      agree_cnt   <= 8'd0;
      done_cnt    <= 8'd0;
      search_cnt  <= 11'd0;
      miss_cnt    <= 8'd0;
      resume      <= 1'b0;
      phase_idx   <= 11'd0;
      corr_val    <= 8'd0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      shift_parse <= 1'b0;
    end else begin
      state       <= state_nx;
      chip_cnt    <= chip_nx;
      agree_cnt   <= agree_nx;
      done_cnt    <= done_nx;
      search_cnt  <= search_nx;
      miss_cnt    <= miss_nx;
      resume      <= resume_nx;
      phase_idx   <= phase_nx;
      corr_val    <= corr_nx;
      locked      <= locked_nx;
      fail        <= fail_nx;
      shift_parse <= shift_nx;
    end
  end

endmodule

// File: tb/tb_m_code_acq_ctrl.sv
// Testbench for m_code_acq_ctrl with CHIP_DIV=8, SAMPLE_PT=4, DWELL_CHIPS=16,
// THRESH=12, CODE_LEN=7, LOSS_CNT=2.
// The generator model plays a period-7 m-sequence (1110010). A local code
// phase that is off by a nonzero shift agrees on at most 8 of 16 chips, so
// only the matching phase can reach THRESH.
// Timing reference: cycle 0 is the first cycle after the start edge.
// The 16th sample closes at cycle 124, CHECK is cycle 125 and SHIFT is
// cycle 126. Each later dwell takes 127 cycles including CHECK and SHIFT.
module tb_m_code_acq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        rx_chip;
  logic        loc_chip;
  logic        shift_parse;
  logic        busy;
  logic        locked;
  logic        fail;
  logic [10:0] phase_idx;
  logic [7:0]  corr_val;

  int checks = 0;
  int errors = 0;

  m_code_acq_ctrl #(
    .CHIP_DIV(8), .SAMPLE_PT(4), .DWELL_CHIPS(16),
    .THRESH(12), .CODE_LEN(7), .LOSS_CNT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rx_chip(rx_chip), .loc_chip(loc_chip), .shift_parse(shift_parse),
    .busy(busy), .locked(locked), .fail(fail),
    .phase_idx(phase_idx), .corr_val(corr_val)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Generator model: a chip lasts 8 clocks. shift_parse restarts the chip
  // counter and advances the local code by one chip.
  logic [6:0] code_seq = 7'b1110010;
  int t_chip  = 0;
  int gen_cnt = 0;
  int gen_ph  = 0;
  int rx_off  = 0;
  int rx_mode = 0;   // 0: code at rx_off, 1: inverted code at rx_off, 2: ~loc_chip

  function automatic logic code_at(int i);
    code_at = code_seq[i % 7];
  endfunction

  always @(posedge clk) begin
    if (shift_parse) begin
      gen_cnt <= 0;
      gen_ph  <= gen_ph + 1;
    end else if (gen_cnt == 7) begin
      gen_cnt <= 0;
      t_chip  <= t_chip + 1;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  always_comb begin
    loc_chip = code_at(t_chip + gen_ph);
    case (rx_mode)
      0:       rx_chip = code_at(t_chip + rx_off);
      1:       rx_chip = ~code_at(t_chip + rx_off);
      default: rx_chip = ~loc_chip;
    endcase
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    int n_sp;
    logic lk125, lk126;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rx_mode = 0;
    tick(); tick();
    checks++; if ({shift_parse, busy, locked, fail, phase_idx, corr_val} !== 23'd0) begin errors++; $display("FAIL reset_in: got %0h exp 0", {shift_parse, busy, locked, fail, phase_idx, corr_val}); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if ({shift_parse, busy, locked, fail, phase_idx, corr_val} !== 23'd0) begin errors++; $display("FAIL idle_outputs: got %0h exp 0", {shift_parse, busy, locked, fail, phase_idx, corr_val}); end
    // local and received codes aligned: lock on the very first dwell
    rx_off = gen_ph % 7;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b exp 1", busy); end
    n_sp = 0; lk125 = 1'bx; lk126 = 1'bx;
    for (int c = 0; c < 128; c++) begin
      if (shift_parse) n_sp++;
      if (c == 125) lk125 = locked;
      if (c == 126) lk126 = locked;
      tick();
    end
    checks++; if (n_sp !== 0) begin errors++; $display("FAIL idle_no_shift: got %0d exp 0", n_sp); end
    checks++; if (lk125 !== 1'b0) begin errors++; $display("FAIL lock_not_in_check: got %0b exp 0", lk125); end
    checks++; if (lk126 !== 1'b1) begin errors++; $display("FAIL lock_latency: got %0b exp 1", lk126); end
    checks++; if (phase_idx !== 11'd0) begin errors++; $display("FAIL lock0_phase: got %0d exp 0", phase_idx); end
    checks++; if (corr_val !== 8'd16) begin errors++; $display("FAIL lock0_corr: got %0d exp 16", corr_val); end
  endtask

  task automatic test_lock_phase3();
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int lock_at;
    exp_q = '{16'd126, 16'd253, 16'd380};
    rx_off = (gen_ph + 3) % 7; rx_mode = 0;
    pulse_start();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL start_clears_lock: got %0b exp 0", locked); end
    lock_at = -1;
    for (int c = 0; c < 700; c++) begin
      if (shift_parse) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL p3_extra_shift: got cycle %0d exp none", c); end
        else begin
          e = exp_q.pop_front();
          if (16'(c) !== e) begin errors++; $display("FAIL p3_shift_time: got cycle %0d exp %0d", c, e); end
        end
      end
      if (locked) begin lock_at = c; break; end
      tick();
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL p3_missing_shifts: got %0d left exp 0", exp_q.size()); end
    checks++; if (lock_at !== 507) begin errors++; $display("FAIL p3_lock_time: got %0d exp 507", lock_at); end
    checks++; if (phase_idx !== 11'd3) begin errors++; $display("FAIL p3_phase: got %0d exp 3", phase_idx); end
    checks++; if (corr_val !== 8'd16) begin errors++; $display("FAIL p3_corr: got %0d exp 16", corr_val); end
  endtask

`ifdef ACQ_TRACK_EN
  task automatic test_track_loss();
    int k, n_sp;
    rx_mode = 1;
    k = -1;
    for (int c = 0; c < 400; c++) begin
      if (!locked) begin k = c; break; end
      tick();
    end
    // two full inverted dwells: the first sample lands at +6, each dwell is 128
    checks++; if (k !== 255) begin errors++; $display("FAIL trk_loss_time: got %0d exp 255", k); end
    checks++; if (shift_parse !== 1'b1) begin errors++; $display("FAIL trk_loss_shift: got %0b exp 1", shift_parse); end
    checks++; if (corr_val !== 8'd0) begin errors++; $display("FAIL trk_loss_corr: got %0d exp 0", corr_val); end
    tick();
    checks++; if (shift_parse !== 1'b0) begin errors++; $display("FAIL trk_single_pulse: got %0b exp 0", shift_parse); end
    checks++; if (phase_idx !== 11'd4) begin errors++; $display("FAIL trk_next_phase: got %0d exp 4", phase_idx); end
    rx_mode = 0;
    n_sp = 0;
    for (int c = 0; c < 1000; c++) begin
      if (locked) break;
      if (shift_parse) n_sp++;
      tick();
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL trk_relock: got %0b exp 1", locked); end
    checks++; if (n_sp !== 6) begin errors++; $display("FAIL trk_relock_shifts: got %0d exp 6", n_sp); end
    checks++; if (phase_idx !== 11'd3) begin errors++; $display("FAIL trk_relock_phase: got %0d exp 3", phase_idx); end
  endtask
`else
  task automatic test_lock_terminal();
    int n_sp;
    rx_mode = 1;
    n_sp = 0;
    for (int c = 0; c < 400; c++) begin
      if (shift_parse) n_sp++;
      tick();
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL nt_locked_held: got %0b exp 1", locked); end
    checks++; if (n_sp !== 0) begin errors++; $display("FAIL nt_no_shift: got %0d exp 0", n_sp); end
    checks++; if (corr_val !== 8'd16) begin errors++; $display("FAIL nt_corr_held: got %0d exp 16", corr_val); end
  endtask
`endif

  task automatic test_abort_lock();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({locked, busy} !== 2'b00) begin errors++; $display("FAIL abl_flags: got %0b exp 00", {locked, busy}); end
    checks++; if (phase_idx !== 11'd3) begin errors++; $display("FAIL abl_phase_kept: got %0d exp 3", phase_idx); end
    checks++; if (corr_val !== 8'd16) begin errors++; $display("FAIL abl_corr_kept: got %0d exp 16", corr_val); end
    tick();
  endtask

  task automatic test_fail();
    int n_sp, fail_at;
    rx_mode = 2;
    pulse_start();
    n_sp = 0; fail_at = -1;
    for (int c = 0; c < 1200; c++) begin
      if (fail) begin fail_at = c; break; end
      if (shift_parse) n_sp++;
      tick();
    end
    checks++; if (fail_at !== 888) begin errors++; $display("FAIL fl_time: got %0d exp 888", fail_at); end
    checks++; if (n_sp !== 6) begin errors++; $display("FAIL fl_shifts: got %0d exp 6", n_sp); end
    checks++; if ({busy, locked} !== 2'b00) begin errors++; $display("FAIL fl_busy_locked: got %0b exp 00", {busy, locked}); end
    checks++; if (corr_val !== 8'd0) begin errors++; $display("FAIL fl_corr: got %0d exp 0", corr_val); end
    checks++; if (phase_idx !== 11'd6) begin errors++; $display("FAIL fl_phase: got %0d exp 6", phase_idx); end
    tick();
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL fl_sticky: got %0b exp 1", fail); end
    pulse_start();
    checks++; if ({fail, busy, phase_idx} !== {2'b01, 11'd0}) begin errors++; $display("FAIL fl_restart: got %0h exp %0h", {fail, busy, phase_idx}, {2'b01, 11'd0}); end
  endtask

  // continues the search started at the end of test_fail (inverted rx)
  task automatic test_abort_shift();
    int seen;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (shift_parse) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL ab_first_shift: got %0d exp 1", seen); end
    tick();
    pulse_start();   // in DWELL: must be ignored
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (shift_parse) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL ab_second_shift: got %0d exp 1", seen); end
    checks++; if (phase_idx !== 11'd1) begin errors++; $display("FAIL ab_start_ignored: got %0d exp 1", phase_idx); end
    abort = 1'b1;
    tick();
    checks++; if ({shift_parse, busy} !== 2'b00) begin errors++; $display("FAIL ab_shift_drop: got %0b exp 00", {shift_parse, busy}); end
    checks++; if (phase_idx !== 11'd1) begin errors++; $display("FAIL ab_phase_kept: got %0d exp 1", phase_idx); end
    tick();
    abort = 1'b0;
    checks++; if ({shift_parse, busy, phase_idx} !== {2'b00, 11'd1}) begin errors++; $display("FAIL ab_hold_idle: got %0h exp %0h", {shift_parse, busy, phase_idx}, {2'b00, 11'd1}); end
  endtask

  task automatic test_start_abort();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if ({busy, phase_idx} !== {1'b0, 11'd1}) begin errors++; $display("FAIL sa_abort_wins: got %0h exp %0h", {busy, phase_idx}, {1'b0, 11'd1}); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sa_stays_idle: got %0b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    int seen;
    rx_mode = 2;
    pulse_start();
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (shift_parse) begin seen = 1; break; end
      tick();
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL ar_shift_seen: got %0d exp 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({shift_parse, busy} !== 2'b00) begin errors++; $display("FAIL ar_immediate: got %0b exp 00", {shift_parse, busy}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({shift_parse, busy, locked, fail, phase_idx, corr_val} !== 23'd0) begin errors++; $display("FAIL ar_idle: got %0h exp 0", {shift_parse, busy, locked, fail, phase_idx, corr_val}); end
  endtask

  initial begin
    test_reset();
    test_lock_phase3();
`ifdef ACQ_TRACK_EN
    test_track_loss();
`else
    test_lock_terminal();
`endif
    test_abort_lock();
    test_fail();
    test_abort_shift();
    test_start_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
